// File: rtl/pipeline_step_ctrl_if.sv
// Command/status bundle between the debug unit and the pipeline step controller.
interface pipeline_step_ctrl_if #(
  parameter int NB_CNT = 32
);
  logic              i_cmd_valid;
  logic [1:0]        i_cmd;
  logic              o_cmd_ready;
  logic              i_halt_wb;
  logic              o_step;
  logic              o_pipe_reset;
  logic [2:0]        o_state;
  logic [NB_CNT-1:0] o_cycle_count;
  logic              o_done;

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_wb,
    output o_cmd_ready, o_step, o_pipe_reset, o_state, o_cycle_count, o_done
  );

  modport master (
    output i_cmd_valid, i_cmd, i_halt_wb,
    input  o_cmd_ready, o_step, o_pipe_reset, o_state, o_cycle_count, o_done
  );
endinterface

// File: rtl/pipeline_step_ctrl.sv
// Pipeline execution controller: run/step/stop/clear from the debug unit,
// freeze on halt in write-back, and count executed pipeline cycles.
module pipeline_step_ctrl #(
  parameter int NB_CNT       = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pipeline_step_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;
  localparam logic [3:0] CLR_LAST  = 4'(CLEAR_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_step;
  logic              r_pipe_reset;
  logic              r_done;
  logic [NB_CNT-1:0] r_count;
  logic [3:0]        r_clr_cnt;
  logic              w_cmd_ready;
  logic              w_cmd_fire;
  logic              w_halt_seen;
  logic              w_enter_clear;

  assign w_cmd_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
  assign w_cmd_fire    = bus.i_cmd_valid && w_cmd_ready;
  // A halt only counts while the pipeline is actually advancing.
  assign w_halt_seen   = r_step && bus.i_halt_wb;
  assign w_enter_clear = (w_state_next == ST_CLEAR) && (r_state != ST_CLEAR);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          case (bus.i_cmd)
            CMD_RUN:   w_state_next = ST_RUN;
            CMD_STEP:  w_state_next = ST_STEP;
            CMD_CLEAR: w_state_next = ST_CLEAR;
            default:   w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (w_halt_seen) begin
          w_state_next = ST_HALTED;
        end else if (w_cmd_fire && bus.i_cmd == CMD_STOP) begin
          w_state_next = ST_IDLE;
        end else if (w_cmd_fire && bus.i_cmd == CMD_CLEAR) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_STEP:   w_state_next = w_halt_seen ? ST_HALTED : ST_IDLE;
      ST_HALTED: begin
        if (w_cmd_fire && bus.i_cmd == CMD_CLEAR) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR:  w_state_next = (r_clr_cnt == 4'd0) ? ST_IDLE : ST_CLEAR;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_step       <= 1'b0;
      r_pipe_reset <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= '0;
      r_clr_cnt    <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_step       <= (w_state_next == ST_RUN) || (w_state_next == ST_STEP);
      r_pipe_reset <= (w_state_next == ST_CLEAR);
      r_done       <= (w_state_next == ST_HALTED) && (r_state != ST_HALTED);
      if (w_enter_clear) begin
        r_clr_cnt <= CLR_LAST;
      end else if (r_state == ST_CLEAR && r_clr_cnt != 4'd0) begin
        r_clr_cnt <= r_clr_cnt - 4'd1;
      end
      // Clearing wins over the last step's increment; otherwise saturate.
      if (w_enter_clear) begin
        r_count <= '0;
      end else if (r_step && (r_count != {NB_CNT{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.o_cmd_ready   = w_cmd_ready;
  assign bus.o_step        = r_step;
  assign bus.o_pipe_reset  = r_pipe_reset;
  assign bus.o_state       = r_state;
  assign bus.o_cycle_count = r_count;
  assign bus.o_done        = r_done;
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl: wide-counter instance plus a 4-bit one for saturation.
module tb_pipeline_step_ctrl;
  logic i_clk;
  logic i_reset;
  int   n_tests;
  int   n_fail;
  int   n_steps;

  pipeline_step_ctrl_if #(.NB_CNT(32)) bus ();
  pipeline_step_ctrl_if #(.NB_CNT(4))  bus4 ();

  pipeline_step_ctrl #(.NB_CNT(32), .CLEAR_CYCLES(2)) u_dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  pipeline_step_ctrl #(.NB_CNT(4), .CLEAR_CYCLES(2)) u_dut4 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a command for exactly one posedge on the wide instance.
  task automatic send_cmd(input logic [1:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_reset = 1'b1;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = 2'd0;
    bus.i_halt_wb    = 1'b0;
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd       = 2'd0;
    bus4.i_halt_wb   = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;

    check_eq("rst_state", 32'(bus.o_state), 32'd0);
    check_eq("rst_step", 32'(bus.o_step), 32'd0);
    check_eq("rst_pipe_reset", 32'(bus.o_pipe_reset), 32'd0);
    check_eq("rst_count", bus.o_cycle_count, 32'd0);
    check_eq("rst_done", 32'(bus.o_done), 32'd0);
    check_eq("rst_ready", 32'(bus.o_cmd_ready), 32'd1);

    // Single step
    send_cmd(2'd1);
    check_eq("step_step", 32'(bus.o_step), 32'd1);
    check_eq("step_state", 32'(bus.o_state), 32'd2);
    check_eq("step_ready", 32'(bus.o_cmd_ready), 32'd0);
    tick();
    check_eq("step_after_step", 32'(bus.o_step), 32'd0);
    check_eq("step_after_state", 32'(bus.o_state), 32'd0);
    check_eq("step_after_ready", 32'(bus.o_cmd_ready), 32'd1);
    check_eq("step_count", bus.o_cycle_count, 32'd1);

    // Clear from IDLE: pipe reset for 2 cycles, then IDLE
    send_cmd(2'd3);
    check_eq("clr1_pipe_reset", 32'(bus.o_pipe_reset), 32'd1);
    check_eq("clr1_state", 32'(bus.o_state), 32'd4);
    check_eq("clr1_ready", 32'(bus.o_cmd_ready), 32'd0);
    check_eq("clr1_count", bus.o_cycle_count, 32'd0);
    tick();
    check_eq("clr2_pipe_reset", 32'(bus.o_pipe_reset), 32'd1);
    check_eq("clr2_state", 32'(bus.o_state), 32'd4);
    tick();
    check_eq("clr3_pipe_reset", 32'(bus.o_pipe_reset), 32'd0);
    check_eq("clr3_state", 32'(bus.o_state), 32'd0);
    check_eq("clr3_ready", 32'(bus.o_cmd_ready), 32'd1);

    // RUN then STOP accepted after 10 run cycles
    send_cmd(2'd0);
    n_steps = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_step) n_steps++;
      if (i == 9) begin
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = 2'd2;
      end
      tick();
    end
    bus.i_cmd_valid = 1'b0;
    check_eq("run_step_cycles", 32'(n_steps), 32'd10);
    check_eq("run_stop_step", 32'(bus.o_step), 32'd0);
    check_eq("run_stop_state", 32'(bus.o_state), 32'd0);
    check_eq("run_stop_count", bus.o_cycle_count, 32'd10);

    // RUN with halt and STOP together in cycle 7: halt wins
    send_cmd(2'd3);
    tick();
    tick();
    send_cmd(2'd0);
    repeat (6) tick();
    bus.i_halt_wb   = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 2'd2;
    tick();
    bus.i_halt_wb   = 1'b0;
    bus.i_cmd_valid = 1'b0;
    check_eq("halt_state", 32'(bus.o_state), 32'd3);
    check_eq("halt_done", 32'(bus.o_done), 32'd1);
    check_eq("halt_step", 32'(bus.o_step), 32'd0);
    check_eq("halt_count", bus.o_cycle_count, 32'd7);
    tick();
    check_eq("halt_done_pulse", 32'(bus.o_done), 32'd0);
    check_eq("halt_state_hold", 32'(bus.o_state), 32'd3);

    // HALTED ignores RUN and STEP
    send_cmd(2'd0);
    check_eq("halted_run_step", 32'(bus.o_step), 32'd0);
    check_eq("halted_run_state", 32'(bus.o_state), 32'd3);
    send_cmd(2'd1);
    check_eq("halted_stp_step", 32'(bus.o_step), 32'd0);
    check_eq("halted_stp_state", 32'(bus.o_state), 32'd3);
    check_eq("halted_count", bus.o_cycle_count, 32'd7);
    send_cmd(2'd3);
    check_eq("hclr1_pipe_reset", 32'(bus.o_pipe_reset), 32'd1);
    check_eq("hclr1_count", bus.o_cycle_count, 32'd0);
    tick();
    check_eq("hclr2_pipe_reset", 32'(bus.o_pipe_reset), 32'd1);
    tick();
    check_eq("hclr3_pipe_reset", 32'(bus.o_pipe_reset), 32'd0);
    check_eq("hclr3_state", 32'(bus.o_state), 32'd0);

    // Latched halt is ignored in IDLE, acted on after the next step
    bus.i_halt_wb = 1'b1;
    tick();
    check_eq("idle_halt_state", 32'(bus.o_state), 32'd0);
    send_cmd(2'd1);
    check_eq("halt_step_state", 32'(bus.o_state), 32'd2);
    tick();
    bus.i_halt_wb = 1'b0;
    check_eq("halt_step_to_halted", 32'(bus.o_state), 32'd3);
    check_eq("halt_step_done", 32'(bus.o_done), 32'd1);
    check_eq("halt_step_count", bus.o_cycle_count, 32'd1);

    // Reset in the second CLEAR cycle
    send_cmd(2'd3);
    tick();
    check_eq("mclr_pipe_reset", 32'(bus.o_pipe_reset), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("mrst_pipe_reset", 32'(bus.o_pipe_reset), 32'd0);
    check_eq("mrst_state", 32'(bus.o_state), 32'd0);
    check_eq("mrst_step", 32'(bus.o_step), 32'd0);
    check_eq("mrst_done", 32'(bus.o_done), 32'd0);
    check_eq("mrst_count", bus.o_cycle_count, 32'd0);
    check_eq("mrst_ready", 32'(bus.o_cmd_ready), 32'd1);

    // 4-bit counter saturates at 15 during a 20-cycle run
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd       = 2'd0;
    tick();
    bus4.i_cmd_valid = 1'b0;
    repeat (15) tick();
    check_eq("sat_at_15", 32'(bus4.o_cycle_count), 32'd15);
    repeat (5) tick();
    check_eq("sat_after_20", 32'(bus4.o_cycle_count), 32'd15);
    check_eq("sat_state", 32'(bus4.o_state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
